// File: rtl/obuf_drain_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obuf_drain_if : output-buffer read port and result-stream bundle          |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface obuf_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      obf0_empty, obf1_empty, obf2_empty;
  logic                      obf0_err, obf1_err, obf2_err;
  logic [2*DATA_WIDTH-1:0]   obf0_out, obf1_out, obf2_out;
  logic                      obf0_rd_en, obf1_rd_en, obf2_rd_en;
  logic                      m_valid;
  logic                      m_ready;
  logic [2*DATA_WIDTH-1:0]   m_data;
  logic [1:0]                m_chan;
  logic                      m_last;
`ifdef OBUF_DRAIN_PARITY_EN
  logic                      m_parity;
`endif

  modport master (
`ifdef OBUF_DRAIN_PARITY_EN
    output m_parity,
`endif
    input  obf0_empty, obf1_empty, obf2_empty,
    input  obf0_err, obf1_err, obf2_err,
    input  obf0_out, obf1_out, obf2_out,
    output obf0_rd_en, obf1_rd_en, obf2_rd_en,
    output m_valid, m_data, m_chan, m_last,
    input  m_ready
  );

  modport slave (
`ifdef OBUF_DRAIN_PARITY_EN
    input  m_parity,
`endif
    output obf0_empty, obf1_empty, obf2_empty,
    output obf0_err, obf1_err, obf2_err,
    output obf0_out, obf1_out, obf2_out,
    input  obf0_rd_en, obf1_rd_en, obf2_rd_en,
    input  m_valid, m_data, m_chan, m_last,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/obuf_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obuf_drain : round-robin read controller merging obf0..2 into one stream  |
// | Option macro: OBUF_DRAIN_PARITY_EN adds m_parity (even parity of m_data)  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module obuf_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16,
  parameter int CNT_W      = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       en,
  input  wire logic       clr_err,
  output logic [2:0]      err_flags,
  output logic            busy,
  obuf_drain_if.master    bus
);

  localparam int               RW       = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        empty_v, err_v;
  logic [2:0]        rd_en_q;
  logic [1:0]        sel_q, last_served_q, pick_ch, cand;
  logic [RW-1:0]     rd_data, m_data_q;
  logic [1:0]        m_chan_q;
  logic              m_valid_q, m_last_q;
  logic [CNT_W-1:0]  cnt_q [3];
  logic              start, capture, accept;

  assign empty_v = {bus.obf2_empty, bus.obf1_empty, bus.obf0_empty};
  assign err_v   = {bus.obf2_err, bus.obf1_err, bus.obf0_err};

  assign bus.obf0_rd_en = rd_en_q[0];
  assign bus.obf1_rd_en = rd_en_q[1];
  assign bus.obf2_rd_en = rd_en_q[2];
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_chan     = m_chan_q;
  assign bus.m_last     = m_last_q;
  assign busy           = (state_q != S_IDLE) || m_valid_q;

  // Search order last+1, last+2, last+0; iterate backwards so the nearest wins.
  always_comb begin
    pick_ch = 2'd0;
    cand    = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last_served_q) + k) % 3);
      if (!empty_v[cand]) pick_ch = cand;
    end
  end

  always_comb begin
    rd_data = bus.obf0_out;
    case (sel_q)
      2'd1:    rd_data = bus.obf1_out;
      2'd2:    rd_data = bus.obf2_out;
      default: rd_data = bus.obf0_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && (empty_v != 3'b111)) begin
          start   = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        capture = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (m_valid_q && bus.m_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q       <= 3'b000;
      sel_q         <= 2'd0;
      last_served_q <= 2'd2;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_chan_q      <= 2'd0;
      m_last_q      <= 1'b0;
      err_flags     <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      rd_en_q <= 3'b000;
      if (start) begin
        sel_q            <= pick_ch;
        rd_en_q[pick_ch] <= 1'b1;
      end
      if (capture) begin
        m_data_q  <= rd_data;
        m_chan_q  <= sel_q;
        m_last_q  <= (cnt_q[sel_q] == LAST_CNT);
        m_valid_q <= 1'b1;
      end
      if (accept) begin
        m_valid_q     <= 1'b0;
        last_served_q <= sel_q;
        cnt_q[sel_q]  <= (cnt_q[sel_q] == LAST_CNT) ? '0 : cnt_q[sel_q] + CNT_W'(1);
      end
      // A same-cycle error beats the clear.
      err_flags <= (clr_err ? 3'b000 : err_flags) | err_v;
    end
  end

`ifdef OBUF_DRAIN_PARITY_EN
  logic m_parity_q;
  assign bus.m_parity = m_parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          m_parity_q <= 1'b0;
    else if (capture) m_parity_q <= ^rd_data;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_obuf_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_obuf_drain : directed self-checking bench for obuf_drain (FRAME_LEN=4) |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_obuf_drain;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr_err;
  logic [2:0] err_flags;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [15:0] mem [3][32];
  int          pushed [3];
  int          popped [3];
  int          rd_idx [3];
  int          exp_cnt [3];
  logic [15:0] hold;

  obuf_drain_if #(.DATA_WIDTH(8)) bus ();

  obuf_drain #(.DATA_WIDTH(8), .FRAME_LEN(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_err   (clr_err),
    .err_flags (err_flags),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Buffer model: data appears one edge after rd_en.
  assign bus.obf0_empty = (pushed[0] == popped[0]);
  assign bus.obf1_empty = (pushed[1] == popped[1]);
  assign bus.obf2_empty = (pushed[2] == popped[2]);

  initial begin
    for (int c = 0; c < 3; c++) popped[c] = 0;
  end

  always @(posedge clk) begin
    if (bus.obf0_rd_en) begin bus.obf0_out <= mem[0][popped[0] % 32]; popped[0] <= popped[0] + 1; end
    if (bus.obf1_rd_en) begin bus.obf1_out <= mem[1][popped[1] % 32]; popped[1] <= popped[1] + 1; end
    if (bus.obf2_rd_en) begin bus.obf2_out <= mem[2][popped[2] % 32]; popped[2] <= popped[2] + 1; end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones({bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}) > 1) viol++;
      if ((bus.obf0_rd_en || bus.obf1_rd_en || bus.obf2_rd_en) && bus.m_valid) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.m_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
  endtask

  // Checks the presented word against the bench's expected buffer contents and frame count.
  task automatic check_word(input string tag, input int ch);
    check({tag, "_chan"}, 32'(bus.m_chan), 32'(ch));
    check({tag, "_data"}, 32'(bus.m_data), 32'(mem[ch][rd_idx[ch]]));
    check({tag, "_last"}, 32'(bus.m_last), 32'(exp_cnt[ch] == 3));
    rd_idx[ch]++;
    exp_cnt[ch] = (exp_cnt[ch] == 3) ? 0 : exp_cnt[ch] + 1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0;
    bus.m_ready = 1'b0;
    bus.obf0_err = 1'b0; bus.obf1_err = 1'b0; bus.obf2_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      pushed[c] = 0; rd_idx[c] = 0; exp_cnt[c] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      mem[0][i] = 16'h0A00 + 16'(i);
      mem[1][i] = 16'h1234 + 16'(i);
      mem[2][i] = 16'h2C00 + 16'(i);
    end
    @(negedge clk); @(negedge clk);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_rden", 32'({bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}), 32'd0);
    check("rst_err", 32'(err_flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'({bus.m_chan, bus.m_last, bus.m_data}), 32'd0);
    rst = 1'b0;

    // Single word on obf1, exact pulse timing
    en = 1'b1;
    pushed[1] = 1;
    @(negedge clk);
    check("t2_rden", 32'({bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}), 32'b010);
    @(negedge clk);
    check("t2_rden_off", 32'({bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}), 32'b000);
    check("t2_wait_valid", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("t2_valid", 32'(bus.m_valid), 32'd1);
    check("t2_data", 32'(bus.m_data), 32'h1234);
    check("t2_chan", 32'(bus.m_chan), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    rd_idx[1] = 1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("t2_accepted", 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b0;

    // Asynchronous reset while a word is held
    pushed[2] = 1;
    wait_valid("t1");
    check("t1_chan", 32'(bus.m_chan), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t1_async_valid", 32'(bus.m_valid), 32'd0);
    check("t1_async_out", 32'({bus.m_chan, bus.m_last, bus.m_data}), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_idx[2] = 1;
    for (int c = 0; c < 3; c++) exp_cnt[c] = 0;

    // Round robin across all three channels
    bus.m_ready = 1'b1;
    for (int c = 0; c < 3; c++) pushed[c] += 2;
    for (int w = 0; w < 6; w++) begin
      wait_valid($sformatf("t3_w%0d", w));
      check_word($sformatf("t3_w%0d", w), w % 3);
      @(negedge clk);
    end

    // Backpressure: word held stable, no reads issued
    bus.m_ready = 1'b0;
    for (int c = 0; c < 3; c++) pushed[c] += 1;
    wait_valid("t4");
    hold = mem[0][rd_idx[0]];
    check_word("t4_first", 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d", i), 32'({bus.m_valid, bus.m_chan, bus.m_data}), 32'({1'b1, 2'd0, hold}));
      check($sformatf("t4_nord%0d", i), 32'({bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}), 32'd0);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("t4_released", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("t4_next_rd", 32'({bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}), 32'b010);
    for (int w = 1; w < 3; w++) begin
      wait_valid($sformatf("t4_w%0d", w));
      check_word($sformatf("t4_w%0d", w), w);
      @(negedge clk);
    end

    // en dropped mid-word: the word completes, then the FSM idles
    pushed[0] += 1; pushed[1] += 1;
    @(negedge clk);
    check("ten_rd0", 32'({bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}), 32'b001);
    en = 1'b0;
    wait_valid("ten");
    check_word("ten_w0", 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ten_idle%0d", i), 32'({busy, bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}), 32'd0);
      @(negedge clk);
    end
    en = 1'b1;
    wait_valid("ten_resume");
    check_word("ten_w1", 1);
    @(negedge clk);

    // Frame marking on ch2 from a fresh counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) exp_cnt[c] = 0;
    pushed[2] += 8;
    for (int w = 0; w < 8; w++) begin
      wait_valid($sformatf("t5_w%0d", w));
      check($sformatf("t5_last%0d", w), 32'(bus.m_last), 32'((w == 3) || (w == 7)));
      check_word($sformatf("t5_w%0d", w), 2);
      @(negedge clk);
    end

    // Sticky error flags and clear priority
    bus.obf2_err = 1'b1;
    @(negedge clk);
    bus.obf2_err = 1'b0;
    check("t5_err_set", 32'(err_flags), 32'b100);
    @(negedge clk); @(negedge clk);
    check("t5_err_sticky", 32'(err_flags), 32'b100);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t5_err_clr", 32'(err_flags), 32'b000);
    bus.obf2_err = 1'b1;
    @(negedge clk);
    bus.obf2_err = 1'b0;
    clr_err = 1'b1; bus.obf0_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0; bus.obf0_err = 1'b0;
    check("t5_err_clr_vs_set", 32'(err_flags), 32'b001);
    @(negedge clk);
    check("t5_err_hold", 32'(err_flags), 32'b001);

`ifdef OBUF_DRAIN_PARITY_EN
    mem[0][rd_idx[0]]     = 16'h0007;
    mem[0][rd_idx[0] + 1] = 16'h0003;
    pushed[0] += 2;
    wait_valid("t6_a");
    check("t6_par_a", 32'(bus.m_parity), 32'd1);
    check_word("t6_a", 0);
    @(negedge clk);
    wait_valid("t6_b");
    check("t6_par_b", 32'(bus.m_parity), 32'd0);
    check_word("t6_b", 0);
    @(negedge clk);
`endif

    @(negedge clk); @(negedge clk);
    check("end_busy", 32'(busy), 32'd0);
    check("rden_exclusive", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
